// File: rtl/eth_tx_framer.sv
// Ethernet GMII transmit framer. It inserts the preamble and SFD, zero-pads short
// payloads, appends the CRC-32 FCS and enforces the inter-frame gap.
module eth_tx_framer #(
  parameter int unsigned MIN_LEN   = 60,
  parameter int unsigned MAX_LEN   = 1514,
  parameter int unsigned IFG_BYTES = 12
) (
  input  logic       clk_tx_i,
  input  logic       rst_n,
  input  logic       mac_tx_valid_i,
  input  logic [7:0] mac_tx_data_i,
  output logic       mac_tx_ack_o,
  output logic [7:0] gmii_txd_o,
  output logic       gmii_tx_en_o,
  output logic       frame_done_o,
  output logic       frame_trunc_o
);

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned CNT_W    = 11;
  localparam int unsigned PRE_W    = 3;
  localparam int unsigned FCS_W    = 2;
  localparam int unsigned CRC_W    = 32;
  localparam int unsigned IFG_W    = (IFG_BYTES > 1) ? $clog2(IFG_BYTES) : 1;
  localparam int unsigned IFG_LAST = (IFG_BYTES > 0) ? IFG_BYTES - 1 : 0;
  localparam int unsigned PRE_LAST = 6;

  localparam logic [CRC_W-1:0]  CRC_POLY = 32'hEDB8_8320;
  localparam logic [CRC_W-1:0]  CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [BYTE_W-1:0] PRE_BYTE = 8'h55;
  localparam logic [BYTE_W-1:0] SFD_BYTE = 8'hD5;
  localparam logic [BYTE_W-1:0] PAD_BYTE = 8'h00;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    SFD,
    DATA,
    PAD,
    FCS,
    IFG
  } state_e;

  state_e              state_q, state_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [FCS_W-1:0]    fcs_idx_q, fcs_idx_d;
  logic [IFG_W-1:0]    ifg_cnt_q, ifg_cnt_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [BYTE_W-1:0]   txd_q, txd_d;
  logic                tx_en_q, tx_en_d;
  logic                done_q, done_d;
  logic                trunc_q, trunc_d;
  logic                ack_c;
  logic [CRC_W-1:0]    fcs_c;

  // One byte of the reflected CRC-32, LSB of the data byte first.
  function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0]  crc_in,
                                                input logic [BYTE_W-1:0] din);
    logic [CRC_W-1:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      c = (c[0] ^ din[i]) ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign fcs_c = ~crc_q;

  always_comb begin
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    byte_cnt_d = byte_cnt_q;
    fcs_idx_d  = fcs_idx_q;
    ifg_cnt_d  = ifg_cnt_q;
    crc_d      = crc_q;
    txd_d      = PAD_BYTE;
    tx_en_d    = 1'b0;
    done_d     = 1'b0;
    trunc_d    = 1'b0;
    ack_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (mac_tx_valid_i) begin
          state_d    = PREAMBLE;
          txd_d      = PRE_BYTE;
          tx_en_d    = 1'b1;
          pre_cnt_d  = PRE_W'(1);
          byte_cnt_d = '0;
          crc_d      = CRC_INIT;
        end
      end

      PREAMBLE: begin
        txd_d     = PRE_BYTE;
        tx_en_d   = 1'b1;
        pre_cnt_d = pre_cnt_q + PRE_W'(1);
        if (pre_cnt_q == PRE_W'(PRE_LAST)) begin
          state_d = SFD;
        end
      end

      SFD: begin
        txd_d   = SFD_BYTE;
        tx_en_d = 1'b1;
        state_d = DATA;
      end

      // Registered output leads the state by one byte, so every exit from DATA
      // already emits the next byte (pad or FCS) to keep tx_en gap-free.
      DATA: begin
        tx_en_d = 1'b1;
        ack_c   = mac_tx_valid_i && (byte_cnt_q < CNT_W'(MAX_LEN));
        if (ack_c) begin
          txd_d      = mac_tx_data_i;
          crc_d      = crc_byte(crc_q, mac_tx_data_i);
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end else if (mac_tx_valid_i) begin
          trunc_d   = 1'b1;
          txd_d     = fcs_c[BYTE_W-1:0];
          fcs_idx_d = FCS_W'(1);
          state_d   = FCS;
        end else if (byte_cnt_q < CNT_W'(MIN_LEN)) begin
          txd_d      = PAD_BYTE;
          crc_d      = crc_byte(crc_q, PAD_BYTE);
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
          state_d    = PAD;
        end else begin
          txd_d     = fcs_c[BYTE_W-1:0];
          fcs_idx_d = FCS_W'(1);
          state_d   = FCS;
        end
      end

      PAD: begin
        tx_en_d = 1'b1;
        if (byte_cnt_q < CNT_W'(MIN_LEN)) begin
          txd_d      = PAD_BYTE;
          crc_d      = crc_byte(crc_q, PAD_BYTE);
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
        end else begin
          txd_d     = fcs_c[BYTE_W-1:0];
          fcs_idx_d = FCS_W'(1);
          state_d   = FCS;
        end
      end

      FCS: begin
        tx_en_d   = 1'b1;
        txd_d     = fcs_c[{fcs_idx_q, 3'b000} +: BYTE_W];
        fcs_idx_d = fcs_idx_q + FCS_W'(1);
        if (fcs_idx_q == FCS_W'(3)) begin
          done_d    = 1'b1;
          ifg_cnt_d = '0;
          state_d   = (IFG_BYTES == 0) ? IDLE : IFG;
        end
      end

      IFG: begin
        ifg_cnt_d = ifg_cnt_q + IFG_W'(1);
        if (ifg_cnt_q == IFG_W'(IFG_LAST)) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_tx_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_cnt_q  <= '0;
      byte_cnt_q <= '0;
      fcs_idx_q  <= '0;
      ifg_cnt_q  <= '0;
      crc_q      <= CRC_INIT;
      txd_q      <= PAD_BYTE;
      tx_en_q    <= 1'b0;
      done_q     <= 1'b0;
      trunc_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_cnt_q  <= pre_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      fcs_idx_q  <= fcs_idx_d;
      ifg_cnt_q  <= ifg_cnt_d;
      crc_q      <= crc_d;
      txd_q      <= txd_d;
      tx_en_q    <= tx_en_d;
      done_q     <= done_d;
      trunc_q    <= trunc_d;
    end
  end

  assign mac_tx_ack_o  = ack_c;
  assign gmii_txd_o    = txd_q;
  assign gmii_tx_en_o  = tx_en_q;
  assign frame_done_o  = done_q;
  assign frame_trunc_o = trunc_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Bench for eth_tx_framer: three parameterisations driven by an ack-following
// upstream model, with the GMII stream checked against a frame-level reference.
module tb_eth_tx_framer;

  localparam int IFG       = 12;
  localparam int TOK_START = 256;
  localparam int RUN_LIMIT = 20000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       valid [3];
  logic [7:0] data  [3];
  logic       ack   [3];
  logic [7:0] txd   [3];
  logic       en    [3];
  logic       done  [3];
  logic       trunc [3];

  always #5 clk = ~clk;

  eth_tx_framer u_def (
    .clk_tx_i(clk), .rst_n(rst_n), .mac_tx_valid_i(valid[0]), .mac_tx_data_i(data[0]),
    .mac_tx_ack_o(ack[0]), .gmii_txd_o(txd[0]), .gmii_tx_en_o(en[0]),
    .frame_done_o(done[0]), .frame_trunc_o(trunc[0]));

  eth_tx_framer #(.MIN_LEN(0)) u_min0 (
    .clk_tx_i(clk), .rst_n(rst_n), .mac_tx_valid_i(valid[1]), .mac_tx_data_i(data[1]),
    .mac_tx_ack_o(ack[1]), .gmii_txd_o(txd[1]), .gmii_tx_en_o(en[1]),
    .frame_done_o(done[1]), .frame_trunc_o(trunc[1]));

  eth_tx_framer #(.MIN_LEN(8), .MAX_LEN(16)) u_trunc (
    .clk_tx_i(clk), .rst_n(rst_n), .mac_tx_valid_i(valid[2]), .mac_tx_data_i(data[2]),
    .mac_tx_ack_o(ack[2]), .gmii_txd_o(txd[2]), .gmii_tx_en_o(en[2]),
    .frame_done_o(done[2]), .frame_trunc_o(trunc[2]));

  typedef struct {
    logic       en;
    logic [7:0] txd;
    logic       done;
    logic       trunc;
    logic       ack;
    logic [7:0] data;
  } smp_t;

  typedef struct {
    int          sel;
    int          len;
    bit          ascii;
    int          exp_en;
    bit          chk_fcs;
    logic [31:0] exp_fcs;
  } vec_t;

  smp_t        log_q[$];
  int          stream_q[$];
  logic [7:0]  pay_q[$];
  logic [7:0]  frame_q[$];
  logic [7:0]  exp_bytes[$];
  int          exp_start[$], exp_len[$], exp_trunc[$];
  int          exp_acks;
  logic [7:0]  got_bytes[$];
  int          got_start[$], got_len[$], got_trunc[$], got_dcnt[$], got_dpos[$];
  logic [31:0] crc_tab [256];
  vec_t        vecs [9];
  int          checks = 0;
  int          failures = 0;

  function automatic int min_of(int sel);
    return (sel == 0) ? 60 : (sel == 1) ? 0 : 8;
  endfunction

  function automatic int max_of(int sel);
    return (sel == 2) ? 16 : 1514;
  endfunction

  function automatic void chk(bit ok, string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] fcs_of_frame();
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    foreach (frame_q[i]) c = (c >> 8) ^ crc_tab[c[7:0] ^ frame_q[i]];
    return ~c;
  endfunction

  function automatic void clear_all();
    log_q.delete(); stream_q.delete();
    exp_bytes.delete(); exp_start.delete(); exp_len.delete(); exp_trunc.delete();
    exp_acks = 0;
  endfunction

  // Expected wire image of one frame built from pay_q[pos +: n].
  function automatic void emit_burst(int sel, int pos, int n, bit t);
    logic [31:0] f;
    frame_q.delete();
    for (int i = 0; i < n; i++) frame_q.push_back(pay_q[pos+i]);
    if (!t) while (frame_q.size() < min_of(sel)) frame_q.push_back(8'h00);
    f = fcs_of_frame();
    exp_start.push_back(exp_bytes.size());
    for (int i = 0; i < 7; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    foreach (frame_q[i]) exp_bytes.push_back(frame_q[i]);
    for (int b = 0; b < 4; b++) exp_bytes.push_back(f[8*b +: 8]);
    exp_len.push_back(12 + frame_q.size());
    exp_trunc.push_back(int'(t));
    exp_acks += n;
  endfunction

  // Queue pay_q upstream followed by `gap` idle cycles, and record its expectation.
  function automatic void add_frame(int sel, int gap);
    int rem, pos;
    if (pay_q.size() == 0) stream_q.push_back(TOK_START);
    else foreach (pay_q[i]) stream_q.push_back(int'(pay_q[i]));
    stream_q.push_back(-gap);
    rem = pay_q.size();
    pos = 0;
    while (rem > max_of(sel)) begin
      emit_burst(sel, pos, max_of(sel), 1'b1);
      pos += max_of(sel);
      rem -= max_of(sel);
    end
    emit_burst(sel, pos, rem, 1'b0);
  endfunction

  task automatic tick(int sel);
    smp_t s;
    int   f;
    @(negedge clk);
    for (int d = 0; d < 3; d++) valid[d] = 1'b0;
    if (stream_q.size() > 0) begin
      f = stream_q[0];
      if (f >= 0) begin
        valid[sel] = 1'b1;
        data[sel]  = (f == TOK_START) ? 8'h00 : 8'(f);
      end
    end
    #3;
    s.en = en[sel]; s.txd = txd[sel]; s.done = done[sel]; s.trunc = trunc[sel];
    s.ack = ack[sel]; s.data = data[sel];
    log_q.push_back(s);
    if (stream_q.size() > 0) begin
      f = stream_q[0];
      if (f == TOK_START) void'(stream_q.pop_front());
      else if (f >= 0) begin
        if (ack[sel]) void'(stream_q.pop_front());
      end else if (f == -1) void'(stream_q.pop_front());
      else stream_q[0] = f + 1;
    end
  endtask

  task automatic run(int sel, string tag);
    int quiet = 0;
    int n = 0;
    while ((stream_q.size() > 0 || quiet < 20) && n < RUN_LIMIT) begin
      tick(sel);
      n++;
      quiet = log_q[log_q.size()-1].en ? 0 : quiet + 1;
    end
    chk(n < RUN_LIMIT, {tag, " run budget"}, n, RUN_LIMIT);
  endtask

  task automatic analyze(bit exact_gap, string tag);
    int   nb, last_end, gap, nmin, mm, gs, es;
    int   idle_bad, ack_bad, xfer_bad, gap_bad, acks;
    bit   in_b;
    smp_t s;
    got_bytes.delete(); got_start.delete(); got_len.delete();
    got_trunc.delete(); got_dcnt.delete(); got_dpos.delete();
    idle_bad = 0; ack_bad = 0; xfer_bad = 0; gap_bad = 0; acks = 0;
    in_b = 1'b0; last_end = -1;
    for (int i = 0; i < log_q.size(); i++) begin
      s = log_q[i];
      if (s.ack) acks++;
      if (s.ack && !s.en) ack_bad++;
      if (s.ack && (i + 1 < log_q.size()) && (log_q[i+1].txd !== s.data)) xfer_bad++;
      if (!s.en) begin
        if (s.txd !== 8'h00 || s.done || s.trunc) idle_bad++;
        if (in_b) begin in_b = 1'b0; last_end = i - 1; end
      end else begin
        if (!in_b) begin
          in_b = 1'b1;
          if (last_end >= 0) begin
            gap = i - last_end - 1;
            if (gap < IFG || (exact_gap && gap != IFG)) gap_bad++;
          end
          got_start.push_back(got_bytes.size());
          got_len.push_back(0); got_trunc.push_back(0);
          got_dcnt.push_back(0); got_dpos.push_back(-1);
        end
        nb = got_len.size() - 1;
        got_bytes.push_back(s.txd);
        if (s.trunc) got_trunc[nb] = got_trunc[nb] + 1;
        if (s.done) begin
          got_dcnt[nb] = got_dcnt[nb] + 1;
          got_dpos[nb] = got_len[nb];
        end
        got_len[nb] = got_len[nb] + 1;
      end
    end
    chk(got_len.size() == exp_len.size(), {tag, " burst count"}, got_len.size(), exp_len.size());
    nmin = (got_len.size() < exp_len.size()) ? got_len.size() : exp_len.size();
    for (int k = 0; k < nmin; k++) begin
      gs = got_start[k]; es = exp_start[k];
      chk(got_len[k] == exp_len[k], $sformatf("%s b%0d tx_en cycles", tag, k), got_len[k], exp_len[k]);
      mm = -1;
      for (int j = 0; j < got_len[k] && j < exp_len[k]; j++)
        if (mm < 0 && got_bytes[gs+j] !== exp_bytes[es+j]) mm = j;
      chk(mm < 0, $sformatf("%s b%0d byte %0d", tag, k, mm),
          (mm < 0) ? 32'h0 : 32'(got_bytes[gs+mm]), (mm < 0) ? 32'h0 : 32'(exp_bytes[es+mm]));
      chk(got_dcnt[k] == 1 && got_dpos[k] == got_len[k] - 1,
          $sformatf("%s b%0d done position", tag, k), got_dpos[k], got_len[k] - 1);
      chk(got_trunc[k] == exp_trunc[k], $sformatf("%s b%0d trunc pulses", tag, k),
          got_trunc[k], exp_trunc[k]);
    end
    chk(idle_bad == 0, {tag, " idle outputs nonzero"}, idle_bad, 0);
    chk(ack_bad == 0, {tag, " ack outside frame"}, ack_bad, 0);
    chk(xfer_bad == 0, {tag, " acked byte not next txd"}, xfer_bad, 0);
    chk(acks == exp_acks, {tag, " ack count"}, acks, exp_acks);
    chk(gap_bad == 0, {tag, " inter-frame gap"}, gap_bad, 0);
  endtask

  task automatic rand_payload(int len);
    pay_q.delete();
    for (int i = 0; i < len; i++) pay_q.push_back(8'($urandom));
  endtask

  initial begin
    logic [31:0] c, got_fcs;
    int          acked, n;
    for (int i = 0; i < 256; i++) begin
      c = 32'(i);
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
      crc_tab[i] = c;
    end

    vecs[0] = '{1,  9, 1'b1, 21, 1'b1, 32'hCBF4_3926};
    vecs[1] = '{0, 42, 1'b0, 72, 1'b0, 32'h0};
    vecs[2] = '{0, 60, 1'b0, 72, 1'b0, 32'h0};
    vecs[3] = '{0, 61, 1'b0, 73, 1'b0, 32'h0};
    vecs[4] = '{0,  1, 1'b0, 72, 1'b0, 32'h0};
    vecs[5] = '{2, 20, 1'b0, 28, 1'b0, 32'h0};
    vecs[6] = '{2, 16, 1'b0, 28, 1'b0, 32'h0};
    vecs[7] = '{2,  3, 1'b0, 20, 1'b0, 32'h0};
    vecs[8] = '{1,  1, 1'b0, 13, 1'b0, 32'h0};

    // Reset state, with valid high so the ack path is exercised too.
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin valid[d] = 1'b1; data[d] = 8'hA5; end
    #12;
    for (int d = 0; d < 3; d++) begin
      chk(en[d] == 1'b0, $sformatf("reset tx_en dut%0d", d), en[d], 0);
      chk(txd[d] == 8'h00, $sformatf("reset txd dut%0d", d), txd[d], 0);
      chk(done[d] == 1'b0 && trunc[d] == 1'b0, $sformatf("reset pulses dut%0d", d),
          {done[d], trunc[d]}, 0);
      chk(ack[d] == 1'b0, $sformatf("reset ack dut%0d", d), ack[d], 0);
    end
    for (int d = 0; d < 3; d++) valid[d] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed single-frame vectors.
    for (int v = 0; v < 9; v++) begin
      clear_all();
      if (vecs[v].ascii) begin
        pay_q.delete();
        for (int i = 0; i < vecs[v].len; i++) pay_q.push_back(8'(8'h31 + i));
      end else rand_payload(vecs[v].len);
      add_frame(vecs[v].sel, 3);
      run(vecs[v].sel, $sformatf("vec%0d", v));
      analyze(1'b0, $sformatf("vec%0d", v));
      chk(got_len.size() > 0 && got_len[0] == vecs[v].exp_en, $sformatf("vec%0d first tx_en", v),
          (got_len.size() > 0) ? got_len[0] : -1, vecs[v].exp_en);
      if (vecs[v].chk_fcs) begin
        got_fcs = 32'h0;
        if (got_len.size() > 0 && got_len[0] >= 4)
          for (int b = 0; b < 4; b++)
            got_fcs[8*b +: 8] = got_bytes[got_start[0] + got_len[0] - 4 + b];
        chk(got_fcs == vecs[v].exp_fcs, $sformatf("vec%0d fcs", v), got_fcs, vecs[v].exp_fcs);
      end
    end

    // Zero-length payload: valid drops before the first DATA cycle.
    clear_all();
    pay_q.delete();
    add_frame(0, 5);
    run(0, "zero_len");
    analyze(1'b0, "zero_len");

    // Second frame held valid through the IFG: exactly IFG idle cycles between.
    clear_all();
    rand_payload(10); add_frame(0, 1);
    rand_payload(70); add_frame(0, 1);
    rand_payload(5);  add_frame(0, 1);
    run(0, "ifg_hold");
    analyze(1'b1, "ifg_hold");

    // Maximum length and one byte over it on the default instance.
    clear_all();
    rand_payload(1514); add_frame(0, 2);
    rand_payload(1520); add_frame(0, 2);
    run(0, "max_len");
    analyze(1'b0, "max_len");

    // Randomized traffic on every instance.
    for (int sel = 0; sel < 3; sel++) begin
      clear_all();
      for (int f = 0; f < 8; f++) begin
        rand_payload((sel == 0) ? $urandom_range(1, 120) : (sel == 1) ? $urandom_range(1, 30)
                                                         : $urandom_range(1, 40));
        add_frame(sel, $urandom_range(1, 20));
      end
      run(sel, $sformatf("rand%0d", sel));
      analyze(1'b0, $sformatf("rand%0d", sel));
    end

    // Reset asserted while payload byte 5 is offered.
    clear_all();
    rand_payload(20);
    add_frame(0, 3);
    acked = 0; n = 0;
    while (acked < 4 && n < 200) begin
      tick(0);
      n++;
      if (log_q[log_q.size()-1].ack) acked++;
    end
    chk(acked == 4, "midrst reach byte 5", acked, 4);
    @(negedge clk);
    valid[0] = 1'b1; data[0] = pay_q[4];
    #1 rst_n = 1'b0;
    #1;
    chk(en[0] == 1'b0, "midrst tx_en", en[0], 0);
    chk(ack[0] == 1'b0, "midrst ack", ack[0], 0);
    chk(txd[0] == 8'h00, "midrst txd", txd[0], 0);
    valid[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_all();
    rand_payload(30);
    add_frame(0, 3);
    run(0, "after_rst");
    analyze(1'b0, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
